gf233_digit_mult: RTL



---
 rtl/gf233_pkg.sv | 25 ++
 rtl/gf233_reduce.sv | 26 ++
 rtl/mult59.sv | 20 ++
 rtl/gf233_digit_mult.sv | 103 ++++++++++
 4 files changed

// File: rtl/gf233_pkg.sv
// Shared constants, state encoding and digit helper for the GF(2^233) multiplier datapath.
// Field polynomial is x^233 + x^74 + 1.
package gf233_pkg;

   localparam int unsigned M       = 233;
   localparam int unsigned K       = 74;
   localparam int unsigned DIGIT_W = 59;
   localparam int unsigned NDIG    = 4;
   localparam int unsigned PROD_W  = 465;
   localparam int unsigned PAD_W   = DIGIT_W * NDIG;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StRed,
      StDone
   } state_t;

   // Digit k of a zero-padded operand: bits [59k+58 : 59k].
   function automatic logic [DIGIT_W-1:0] digit_sel(input logic [PAD_W-1:0] v,
                                                    input logic [1:0]       k);
      return v[DIGIT_W*k +: DIGIT_W];
   endfunction

endpackage

// File: rtl/gf233_reduce.sv
// Combinational reduction of a 465-bit unreduced product modulo x^233 + x^74 + 1.
// Two trinomial folds; the second fold cannot overflow again.
module gf233_reduce
   import gf233_pkg::*;
(
   input  logic [PROD_W-1:0] i_p,
   output logic [M-1:0]      o_c
);

   logic [M-2:0]   w_h;
   logic [M+K-2:0] w_t;
   logic [K-2:0]   w_g;

   assign w_h = i_p[PROD_W-1:M];

   assign w_t = {{(K-1){1'b0}}, i_p[M-1:0]}
              ^ {{K{1'b0}}, w_h}
              ^ {w_h, {K{1'b0}}};

   assign w_g = w_t[M+K-2:M];

   assign o_c = w_t[M-1:0]
              ^ {{(M-K+1){1'b0}}, w_g}
              ^ {{(M-2*K+1){1'b0}}, w_g, {K{1'b0}}};

endmodule

// File: rtl/mult59.sv
// Combinational 59x59-bit carry-less (GF(2)[x]) multiplier.
// Output bit 117 is always zero; the port is kept 118 bits wide for a clean digit layout.
module mult59
   import gf233_pkg::*;
(
   input  logic [DIGIT_W-1:0]   i_a,
   input  logic [DIGIT_W-1:0]   i_b,
   output logic [2*DIGIT_W-1:0] o_p
);

   always_comb begin
      o_p = '0;
      for (int k = 0; k < DIGIT_W; k++) begin
         if (i_b[k]) begin
            o_p = o_p ^ ({{DIGIT_W{1'b0}}, i_a} << k);
         end
      end
   end

endmodule

// File: rtl/gf233_digit_mult.sv
// Sequential GF(2^233) multiplier: 16 digit products through one mult59 accumulate into a
// 465-bit unreduced product, followed by a one-cycle trinomial reduction.
module gf233_digit_mult
   import gf233_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [M-1:0] a,
   input  logic [M-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [M-1:0] c
);

   state_t              r_state;
   logic [M-1:0]        r_a;
   logic [M-1:0]        r_b;
   logic [PROD_W-1:0]   r_acc;
   logic [1:0]          r_i;
   logic [1:0]          r_j;

   logic [PAD_W-1:0]    w_a_pad;
   logic [PAD_W-1:0]    w_b_pad;
   logic [DIGIT_W-1:0]  w_da;
   logic [DIGIT_W-1:0]  w_db;
   logic [2*DIGIT_W-1:0] w_prod;
   logic [2:0]          w_dsum;
   logic [PROD_W-1:0]   w_term;
   logic [M-1:0]        w_red;

   assign w_a_pad = {{(PAD_W-M){1'b0}}, r_a};
   assign w_b_pad = {{(PAD_W-M){1'b0}}, r_b};
   assign w_da    = digit_sel(w_a_pad, r_i);
   assign w_db    = digit_sel(w_b_pad, r_j);
   assign w_dsum  = {1'b0, r_i} + {1'b0, r_j};

   mult59 u_mult59 (
      .i_a (w_da),
      .i_b (w_db),
      .o_p (w_prod)
   );

   // Highest term lands at bit 464 since digit 3 carries only 56 live bits.
   assign w_term = {{(PROD_W-2*DIGIT_W){1'b0}}, w_prod} << (DIGIT_W * 32'(w_dsum));

   gf233_reduce u_reduce (
      .i_p (r_acc),
      .o_c (w_red)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_i     <= '0;
         r_j     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         c       <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_acc   <= '0;
                  r_i     <= '0;
                  r_j     <= '0;
                  busy    <= 1'b1;
                  r_state <= StMul;
               end
            end
            StMul: begin
               r_acc      <= r_acc ^ w_term;
               {r_i, r_j} <= {r_i, r_j} + 4'd1;
               if (r_i == 2'd3 && r_j == 2'd3) begin
                  r_state <= StRed;
               end
            end
            StRed: begin
               c       <= w_red;
               busy    <= 1'b0;
               done    <= 1'b1;
               r_state <= StDone;
            end
            StDone: begin
               done    <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule
